// File: rtl/fpu_div.sv
// Iterative IEEE 754 single-precision divider: restoring radix-2 mantissa
// division, one quotient bit per clock, truncating rounding, flush-to-zero.
module fpu_div #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             state_r, state_next_s;
  logic               sign_r;
  logic [QBITS-1:0]   r_r, q_r;
  logic [23:0]        d_r;
  logic signed [9:0]  e_r;
  logic [4:0]         cnt_r;

  logic [7:0]         ea_s, eb_s;
  logic [22:0]        ma_s, mb_s;
  logic               sign_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic               special_s, special_dbz_s;
  logic [31:0]        special_res_s;
  logic [QBITS-1:0]   diff_s;
  logic               ge_s;
  logic signed [9:0]  norm_e_s;
  logic [22:0]        norm_mant_s;
  logic [31:0]        norm_res_s;

  assign ea_s     = a[30:23];
  assign eb_s     = b[30:23];
  assign ma_s     = a[22:0];
  assign mb_s     = b[22:0];
  assign sign_s   = a[31] ^ b[31];
  // Exponent field 0 is treated as zero regardless of mantissa (FTZ).
  assign a_zero_s = (ea_s == 8'd0);
  assign b_zero_s = (eb_s == 8'd0);
  assign a_inf_s  = (ea_s == 8'hFF) && (ma_s == 23'd0);
  assign b_inf_s  = (eb_s == 8'hFF) && (mb_s == 23'd0);
  assign a_nan_s  = (ea_s == 8'hFF) && (ma_s != 23'd0);
  assign b_nan_s  = (eb_s == 8'hFF) && (mb_s != 23'd0);

  assign diff_s   = r_r - {1'b0, d_r};
  assign ge_s     = (r_r >= {1'b0, d_r});

  // Special-operand classification, in priority order
  always_comb begin
    special_s     = 1'b1;
    special_dbz_s = 1'b0;
    special_res_s = 32'h0000_0000;
    if (a_nan_s || b_nan_s) begin
      special_res_s = QNAN;
    end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
      special_res_s = QNAN;
    end else if (a_inf_s) begin
      special_res_s = {sign_s, 8'hFF, 23'd0};
    end else if (b_inf_s) begin
      special_res_s = {sign_s, 31'd0};
    end else if (b_zero_s) begin
      special_res_s = {sign_s, 8'hFF, 23'd0};
      special_dbz_s = 1'b1;
    end else if (a_zero_s) begin
      special_res_s = {sign_s, 31'd0};
    end else begin
      special_s = 1'b0;
    end
  end

  // Normalisation and overflow/underflow packing of the finished quotient
  always_comb begin
    norm_e_s    = e_r;
    norm_mant_s = q_r[QBITS-2:1];
    norm_res_s  = 32'h0000_0000;
    if (q_r[QBITS-1]) begin
      norm_mant_s = q_r[QBITS-2:1];
      norm_e_s    = e_r;
    end else begin
      norm_mant_s = q_r[QBITS-3:0];
      norm_e_s    = e_r - 10'sd1;
    end
    if (norm_e_s >= 10'sd255) begin
      norm_res_s = {sign_r, 8'hFF, 23'd0};
    end else if (norm_e_s <= 10'sd0) begin
      norm_res_s = {sign_r, 31'd0};
    end else begin
      norm_res_s = {sign_r, norm_e_s[7:0], norm_mant_s};
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = special_s ? DONE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 5'd0) begin
          state_next_s = NORM;
        end else begin
          state_next_s = CALC;
        end
      end
      NORM:    state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 32'h0000_0000;
      div_by_zero <= 1'b0;
      sign_r      <= 1'b0;
      r_r         <= '0;
      q_r         <= '0;
      d_r         <= 24'd0;
      e_r         <= 10'sd0;
      cnt_r       <= 5'd0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == CALC) || (state_next_s == NORM);
      done    <= (state_next_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            sign_r <= sign_s;
            if (special_s) begin
              result      <= special_res_s;
              div_by_zero <= special_dbz_s;
            end else begin
              r_r   <= {2'b01, ma_s};
              d_r   <= {1'b1, mb_s};
              q_r   <= '0;
              e_r   <= $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
              cnt_r <= 5'd24;
            end
          end
        end
        CALC: begin
          // r < 2d holds throughout, so dropping the top bit before the shift is lossless.
          if (ge_s) begin
            q_r <= {q_r[QBITS-2:0], 1'b1};
            r_r <= {diff_s[QBITS-2:0], 1'b0};
          end else begin
            q_r <= {q_r[QBITS-2:0], 1'b0};
            r_r <= {r_r[QBITS-2:0], 1'b0};
          end
          cnt_r <= cnt_r - 5'd1;
        end
        NORM: begin
          result      <= norm_res_s;
          div_by_zero <= 1'b0;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: doc/fpu_div.md
Name: fpu_div

Overview:
- Iterative IEEE 754 single-precision divider (a / b): the inverse operation for the FPU datapath, next to the combinational adder.
- Restoring radix-2 mantissa division, one quotient bit per clock.
- Start/busy/done handshake, so it fits the multi-cycle FPU instruction path.
- Rounding is truncation toward zero. Subnormal inputs and underflowing results are flushed to zero.

Parameters:
- QBITS, 25, number of quotient bits produced (24 significand bits plus 1 bit for normalization); fixed, not for re-tuning.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  32  dividend, IEEE 754 single
- b  in  32  divisor, IEEE 754 single
- busy  out  1  high in CALC and NORM
- done  out  1  one-cycle pulse, high in DONE
- result  out  32  quotient; valid when done is high, held until the next accepted start
- div_by_zero  out  1  set with done when finite non-zero / zero; held with result

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 on an edge forces state=IDLE, busy=0, done=0, result=0, div_by_zero=0, and clears internal registers. This applies in any state, including mid-CALC, and rst has priority over start.
- States: IDLE, CALC, NORM, DONE.
- IDLE/DONE with start=1:
  - Latch sign = a[31]^b[31] and classify both operands.
  - Exponent field 0 means zero (FTZ). Exponent 255 means inf or NaN.
  - Special case: compute result and go to DONE.
  - Otherwise: r = {1'b0,1,ma}; d = {1,mb}; e = ea - eb + 127 as 10-bit signed; counter = 24; go to CALC.
- IDLE/DONE with start=0: DONE returns to IDLE; IDLE stays.
- CALC, each cycle:
  - If r >= d: q = {q[23:0],1} and r = (r-d)<<1.
  - Else: q = {q[23:0],0} and r = r<<1.
  - Counter decrements. After 25 iterations (counter was 0) go to NORM.
- NORM:
  - If q[24]=1: mant = q[23:1]. Else: mant = q[22:0] and e = e-1.
  - If e >= 255: result = {sign,8'hFF,0}.
  - Else if e <= 0: result = {sign,31'b0}.
  - Else: result = {sign,e[7:0],mant}.
  - Go to DONE.
- Latency: start accepted at edge 0 → done high in cycle 27 for normal operands, cycle 1 for special cases. Back-to-back starts are allowed from DONE.
- start while busy is ignored: no latch, no effect on the current operation.
- result and div_by_zero change only in NORM/special-latch/reset. div_by_zero is otherwise 0 for the operation.
- Special-case priority:
  1. Either input NaN → 7FC00000.
  2. inf/inf or 0/0 → 7FC00000.
  3. inf/x → {sign,FF,0}.
  4. x/inf → {sign,0}.
  5. x/0 (x finite non-zero) → {sign,FF,0} with div_by_zero=1.
  6. 0/x → {sign,0}.
- Widths: r and d are 25 bits, q is 25 bits, e is 10-bit signed. No overflow inside CALC, because r < 2d is invariant.

Test Plan:
- 40C00000 / 40000000 (6/2) → result=40400000, done exactly 27 cycles after start, busy high cycles 1–26, div_by_zero=0.
- 3F800000 / 40400000 (1/3) → 3EAAAAAA (truncated, not AAAB); then C0000000 / 3F000000 (-2/0.5) started in the DONE cycle → C0800000.
- BF800000 / 00000000 → FF800000, div_by_zero=1, done in cycle 1. Also 00000000/00000000 → 7FC00000, 7F800000/7F800000 → 7FC00000, 7FC00001/3F800000 → 7FC00000.
- Overflow 7F000000 / 3E800000 → 7F800000. Underflow 00800000 / 40000000 → 00000000. Subnormal 00400000 / 3F800000 → 00000000.
- Start pulsed again at cycle 5 during CALC with different operands → ignored; first result is delivered unchanged at cycle 27.
- rst asserted at cycle 10 of CALC → next edge busy=0, done=0, result=0, state IDLE; a fresh start then completes normally in 27 cycles.
